// File: rtl/cpu_defs_pkg.sv
// Shared CPU pipeline definitions: widths, register/instruction constants,
// Tnew encodings and control-bundle field offsets.
package cpu_defs;

  localparam int unsigned DW     = 32;
  localparam int unsigned CTRL_W = 16;
  localparam int unsigned TNEW_W = 2;
  localparam int unsigned REG_W  = 5;

  localparam logic [31:0]       NOP_INSTR = 32'h0;
  localparam logic [REG_W-1:0]  REG_ZERO  = 5'd0;

  localparam logic [TNEW_W-1:0] TNEW_NONE = 2'd0;
  localparam logic [TNEW_W-1:0] TNEW_ALU  = 2'd1;
  localparam logic [TNEW_W-1:0] TNEW_LOAD = 2'd2;

  // Bit offsets of the fields inside the opaque control bundle decoded in D
  localparam int unsigned CTRL_REG_WRITE = 0;
  localparam int unsigned CTRL_MEM_READ  = 1;
  localparam int unsigned CTRL_MEM_WRITE = 2;
  localparam int unsigned CTRL_ALU_SRC   = 3;
  localparam int unsigned CTRL_ALU_OP    = 4;
  localparam int unsigned CTRL_ALU_OP_W  = 4;
  localparam int unsigned CTRL_BRANCH    = 8;
  localparam int unsigned CTRL_JUMP      = 9;
  localparam int unsigned CTRL_WB_SEL    = 10;
  localparam int unsigned CTRL_WB_SEL_W  = 2;

endpackage

// File: rtl/tnew_dec.sv
// Saturating Tnew decrementer; a write to $0 never produces a pending result.
module tnew_dec
  import cpu_defs::*;
#(
  parameter int unsigned TW = TNEW_W
) (
  input  logic [TW-1:0]    tnew,
  input  logic [REG_W-1:0] a3,
  output logic [TW-1:0]    tnew_next_c
);

  always_comb begin
    tnew_next_c = '0;
    if ((a3 != REG_ZERO) && (tnew != '0)) begin
      tnew_next_c = tnew - TW'(1);
    end
  end

endmodule

// File: rtl/d_e_pipe_reg.sv
// Decode/Execute pipeline register with bubble insertion, E-stage freeze
// and a saturating debug count of inserted bubbles.
module d_e_pipe_reg
  import cpu_defs::*;
#(
  parameter int unsigned DW     = cpu_defs::DW,
  parameter int unsigned CTRL_W = cpu_defs::CTRL_W,
  parameter int unsigned TNEW_W = cpu_defs::TNEW_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic [DW-1:0]     D_PC,
  input  logic [DW-1:0]     D_Instr,
  input  logic [DW-1:0]     D_RD1,
  input  logic [DW-1:0]     D_RD2,
  input  logic [DW-1:0]     D_EXT,
  input  logic [4:0]        D_A3,
  input  logic [TNEW_W-1:0] D_Tnew,
  input  logic [CTRL_W-1:0] D_Ctrl,
  output logic [DW-1:0]     E_PC,
  output logic [DW-1:0]     E_Instr,
  output logic [DW-1:0]     E_RD1,
  output logic [DW-1:0]     E_RD2,
  output logic [DW-1:0]     E_EXT,
  output logic [4:0]        E_A3,
  output logic [TNEW_W-1:0] E_Tnew,
  output logic [CTRL_W-1:0] E_Ctrl,
  output logic              E_valid,
  output logic [15:0]       bubble_cnt
);

  logic [TNEW_W-1:0] tnew_next_c;

  tnew_dec #(.TW(TNEW_W)) u_tnew_dec (
    .tnew        (D_Tnew),
    .a3          (D_A3),
    .tnew_next_c (tnew_next_c)
  );

  // Pipeline payload: bubble beats load, load beats hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      E_PC    <= '0;
      E_Instr <= '0;
      E_RD1   <= '0;
      E_RD2   <= '0;
      E_EXT   <= '0;
      E_A3    <= '0;
      E_Tnew  <= '0;
      E_Ctrl  <= '0;
      E_valid <= 1'b0;
    end else if (clr) begin
      // Bubble keeps the stalled PC for exception attribution
      E_PC    <= D_PC;
      E_Instr <= DW'(NOP_INSTR);
      E_RD1   <= '0;
      E_RD2   <= '0;
      E_EXT   <= '0;
      E_A3    <= REG_ZERO;
      E_Tnew  <= '0;
      E_Ctrl  <= '0;
      E_valid <= 1'b0;
    end else if (en) begin
      E_PC    <= D_PC;
      E_Instr <= D_Instr;
      E_RD1   <= D_RD1;
      E_RD2   <= D_RD2;
      E_EXT   <= D_EXT;
      E_A3    <= D_A3;
      E_Tnew  <= tnew_next_c;
      E_Ctrl  <= D_Ctrl;
      E_valid <= 1'b1;
    end
  end

  // Saturating bubble counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_cnt <= '0;
    end else if (clr && (bubble_cnt != 16'hFFFF)) begin
      bubble_cnt <= bubble_cnt + 16'd1;
    end
  end

endmodule
